// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised single-clock VGA timing generator. One counter pair (h, v)
// advances on every PIX_EN tick. Two registered stages follow it:
//   stage A : pixel address, raw sync flags and the active-area flag
//   stage B : HS/VS at the configured polarity, DE and the blanked colour
// The strobes LINE_START / FRAME_START are one CLK wide and follow the tick
// on which the counters wrap.
//
// Optional feature: define VGA_TESTPAT_EN to add the TESTPAT input. While
// TESTPAT is high, stage B shows eight vertical colour bars in place of
// COLOUR_IN. Without the macro the port does not exist.
//
// Ports
//   CLK          in   system clock
//   RESET        in   synchronous active-high reset
//   PIX_EN       in   one-CLK pixel tick (tie high when CLK is the pixel clock)
//   TESTPAT      in   colour-bar select (only with VGA_TESTPAT_EN)
//   COLOUR_IN    in   colour for the address issued on the previous tick
//   ADDRH        out  active-area column, 0 outside the active columns
//   ADDRV        out  active-area row, 0 outside the active rows
//   COLOUR_OUT   out  colour to the DAC, 0 whenever DE is low
//   HS, VS       out  syncs at HS_POL / VS_POL active level
//   DE           out  display enable, aligned with COLOUR_OUT
//   LINE_START   out  one-CLK strobe after the tick where h wraps to 0
//   FRAME_START  out  one-CLK strobe after the tick where (h,v) wraps to (0,0)
//
// Colour-source contract: ADDRH/ADDRV change only one CLK after a PIX_EN
// tick; the source must present the matching COLOUR_IN before the next
// PIX_EN tick, which is when stage B samples it. There is no back-pressure.
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 29,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   HCW      = 11,
  parameter int   VCW      = 10,
  parameter int   COLOUR_W = 12
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                PIX_EN,
`ifdef VGA_TESTPAT_EN
  input  logic                TESTPAT,
`endif
  input  logic [COLOUR_W-1:0] COLOUR_IN,
  output logic [HCW-1:0]      ADDRH,
  output logic [VCW-1:0]      ADDRV,
  output logic [COLOUR_W-1:0] COLOUR_OUT,
  output logic                HS,
  output logic                VS,
  output logic                DE,
  output logic                LINE_START,
  output logic                FRAME_START
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  // Inclusive bounds, so the last active column still fits in HCW bits
  // even with a zero front porch.
  localparam logic [HCW-1:0] H_LAST      = HCW'(H_TOTAL - 1);
  localparam logic [HCW-1:0] H_SYNC_END  = HCW'(H_SYNC);
  localparam logic [HCW-1:0] H_ACT_FIRST = HCW'(H_SYNC + H_BP);
  localparam logic [HCW-1:0] H_ACT_LAST  = HCW'(H_SYNC + H_BP + H_ACTIVE - 1);

  localparam logic [VCW-1:0] V_LAST      = VCW'(V_TOTAL - 1);
  localparam logic [VCW-1:0] V_SYNC_END  = VCW'(V_SYNC);
  localparam logic [VCW-1:0] V_ACT_FIRST = VCW'(V_SYNC + V_BP);
  localparam logic [VCW-1:0] V_ACT_LAST  = VCW'(V_SYNC + V_BP + V_ACTIVE - 1);

  // Raster position
  logic [HCW-1:0] h_cnt;
  logic [VCW-1:0] v_cnt;

  // Stage A (ADDRH/ADDRV are the stage A address registers themselves)
  logic hs_a;
  logic vs_a;
  logic de_a;

  // Decode of the current (pre-increment) position
  logic h_wrap;
  logic v_wrap;
  logic h_act;
  logic v_act;

  always_comb begin
    h_wrap = (h_cnt == H_LAST);
    v_wrap = (v_cnt == V_LAST);
    h_act  = (h_cnt >= H_ACT_FIRST) && (h_cnt <= H_ACT_LAST);
    v_act  = (v_cnt >= V_ACT_FIRST) && (v_cnt <= V_ACT_LAST);
  end

  // Colour that stage B shows when the pixel is active
  logic [COLOUR_W-1:0] colour_sel;

`ifdef VGA_TESTPAT_EN
  localparam int CH_W = COLOUR_W / 3;

  // Bar 0..7 = white, yellow, cyan, green, magenta, red, blue, black.
  // Each channel is CH_W bits wide, R in the MSBs; any spare LSBs stay 0.
  function automatic logic [COLOUR_W-1:0] bar_colour(input logic [2:0] bar);
    logic [2:0]          rgb;
    logic [COLOUR_W-1:0] c;
    case (bar)
      3'd0:    rgb = 3'b111;
      3'd1:    rgb = 3'b110;
      3'd2:    rgb = 3'b011;
      3'd3:    rgb = 3'b010;
      3'd4:    rgb = 3'b101;
      3'd5:    rgb = 3'b100;
      3'd6:    rgb = 3'b001;
      default: rgb = 3'b000;
    endcase
    c = '0;
    for (int i = 0; i < CH_W; i++) begin
      c[COLOUR_W-1-i]          = rgb[2];
      c[COLOUR_W-1-CH_W-i]     = rgb[1];
      c[COLOUR_W-1-2*CH_W-i]   = rgb[0];
    end
    return c;
  endfunction

  logic [2:0] bar_idx;

  always_comb begin
    // The bar follows the stage A column, i.e. the pixel stage B is about
    // to display.
    bar_idx    = 3'((32'(ADDRH) * 32'd8) / 32'(H_ACTIVE));
    colour_sel = COLOUR_IN;
    if (TESTPAT) begin
      colour_sel = bar_colour(bar_idx);
    end
  end
`else
  always_comb begin
    colour_sel = COLOUR_IN;
  end
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      ADDRH       <= '0;
      ADDRV       <= '0;
      hs_a        <= 1'b0;
      vs_a        <= 1'b0;
      de_a        <= 1'b0;
      HS          <= ~HS_POL;
      VS          <= ~VS_POL;
      DE          <= 1'b0;
      COLOUR_OUT  <= '0;
      LINE_START  <= 1'b0;
      FRAME_START <= 1'b0;
    end else begin
      // Strobes are rewritten every CLK so they drop after one cycle even
      // when PIX_EN is slower than CLK.
      LINE_START  <= PIX_EN && h_wrap;
      FRAME_START <= PIX_EN && h_wrap && v_wrap;

      if (PIX_EN) begin
        // Counters
        if (h_wrap) begin
          h_cnt <= '0;
          if (v_wrap) begin
            v_cnt <= '0;
          end else begin
            v_cnt <= v_cnt + 1'b1;
          end
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end

        // Stage A: subtraction only inside the active range, so no underflow
        ADDRH <= h_act ? (h_cnt - H_ACT_FIRST) : '0;
        ADDRV <= v_act ? (v_cnt - V_ACT_FIRST) : '0;
        hs_a  <= (h_cnt < H_SYNC_END);
        vs_a  <= (v_cnt < V_SYNC_END);
        de_a  <= h_act && v_act;

        // Stage B
        HS         <= hs_a ? HS_POL : ~HS_POL;
        VS         <= vs_a ? VS_POL : ~VS_POL;
        DE         <= de_a;
        COLOUR_OUT <= de_a ? colour_sel : '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Bench for vga_timing_gen on a small raster: H 8/8/32/8 (56 per line),
// V 1/2/4/1 (8 lines), HS active-high, VS active-low. Active columns are
// h = 16..47, active rows v = 3..6, HS active for h < 8, VS for v < 1.
// COLOUR_IN is fed back from the address outputs as {0, ADDRV, 00, ADDRH}.
//
// The stimulus process drives RESET/PIX_EN one cycle at a time and pushes
// the outputs expected after that cycle's clock edge. The expectation is
// written as a function of k, the number of PIX_EN ticks since reset:
// stage A shows position k-1, stage B shows position k-2. The monitor pops
// one expectation per cycle and also gathers period/width statistics that
// are compared against hand-computed numbers at the end.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

  localparam int   H_SYNC = 8, H_BP = 8, H_ACTIVE = 32, H_FP = 8;
  localparam int   V_SYNC = 1, V_BP = 2, V_ACTIVE = 4, V_FP = 1;
  localparam logic HS_POL = 1'b1;
  localparam logic VS_POL = 1'b0;
  localparam int   HCW = 6, VCW = 3, CW = 12;

  localparam int HT = 56;
  localparam int VT = 8;
  localparam int W  = HCW + VCW + CW + 5;

  // Clock / reset / DUT
  logic          clk;
  logic          rst;
  logic          pix_en;
  logic [CW-1:0] colour_in;
  logic [HCW-1:0] addrh;
  logic [VCW-1:0] addrv;
  logic [CW-1:0] colour_out;
  logic          hs, vs, de, line_start, frame_start;
`ifdef VGA_TESTPAT_EN
  logic          testpat;
`endif

  assign colour_in = {1'b0, addrv, 2'b00, addrh};

  vga_timing_gen #(
    .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP),
    .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACTIVE(V_ACTIVE), .V_FP(V_FP),
    .HS_POL(HS_POL), .VS_POL(VS_POL),
    .HCW(HCW), .VCW(VCW), .COLOUR_W(CW)
  ) dut (
    .CLK(clk),
    .RESET(rst),
    .PIX_EN(pix_en),
`ifdef VGA_TESTPAT_EN
    .TESTPAT(testpat),
`endif
    .COLOUR_IN(colour_in),
    .ADDRH(addrh),
    .ADDRV(addrv),
    .COLOUR_OUT(colour_out),
    .HS(hs),
    .VS(vs),
    .DE(de),
    .LINE_START(line_start),
    .FRAME_START(frame_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  ticks    = 0;
  int  phase    = 0;
  bit  tp_mode  = 1'b0;
  bit  done     = 1'b0;

  // Hand-listed bar colours for a 12-bit bus
  function automatic logic [CW-1:0] bar_rgb(input int b);
    case (b)
      0:       return 12'hFFF;
      1:       return 12'hFF0;
      2:       return 12'h0FF;
      3:       return 12'h0F0;
      4:       return 12'hF0F;
      5:       return 12'hF00;
      6:       return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  // Expected outputs after the edge that brought the tick count to k.
  // tick = this edge was an enabled tick (strobes only follow a tick).
  function automatic logic [W-1:0] model(input int k, input bit tick, input bit tp);
    int p, hp, vp, q, hq, vq;
    logic [HCW-1:0] e_ah;
    logic [VCW-1:0] e_av;
    logic [CW-1:0]  e_col;
    logic e_hs, e_vs, e_de, e_ls, e_fs;
    e_ah = '0; e_av = '0; e_col = '0;
    e_hs = ~HS_POL; e_vs = ~VS_POL; e_de = 1'b0; e_ls = 1'b0; e_fs = 1'b0;
    if (k >= 1) begin
      p  = k - 1;
      hp = p % HT;
      vp = (p / HT) % VT;
      if (hp >= 16 && hp < 48) e_ah = HCW'(hp - 16);
      if (vp >= 3 && vp < 7)   e_av = VCW'(vp - 3);
      if (tick && hp == HT - 1) begin
        e_ls = 1'b1;
        e_fs = (vp == VT - 1);
      end
    end
    if (k >= 2) begin
      q  = k - 2;
      hq = q % HT;
      vq = (q / HT) % VT;
      e_hs = (hq < 8) ? HS_POL : ~HS_POL;
      e_vs = (vq < 1) ? VS_POL : ~VS_POL;
      e_de = (hq >= 16 && hq < 48 && vq >= 3 && vq < 7);
      if (e_de) begin
        if (tp) e_col = bar_rgb((hq - 16) / 4);
        else    e_col = {1'b0, VCW'(vq - 3), 2'b00, HCW'(hq - 16)};
      end
    end
    return {e_ah, e_av, e_col, e_hs, e_vs, e_de, e_ls, e_fs};
  endfunction

  // Driver: one CLK cycle of stimulus plus its expectation
  task automatic step(input logic en, input logic r);
    @(negedge clk);
    pix_en = en;
    rst    = r;
    if (r)       ticks = 0;
    else if (en) ticks = ticks + 1;
    exp_q.push_back(model(ticks, en && !r, tp_mode));
  endtask

  // Stimulus
  initial begin
    rst    = 1'b1;
    pix_en = 1'b0;
`ifdef VGA_TESTPAT_EN
    testpat = 1'b0;
`endif
    // Reset with PIX_EN high: ticks must be ignored
    phase = 0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);

    // Continuous ticks, a little over two frames
    phase = 1;
    for (int i = 0; i < 910; i++) step(1'b1, 1'b0);

    // One tick in four, over two frames
    phase = 2;
    for (int i = 0; i < 3700; i++) step((i % 4) == 0, 1'b0);

    // Irregular ticks, then a mid-frame reset with random PIX_EN, then one
    // full frame from the release
    phase = 3;
    for (int i = 0; i < 700; i++) step(1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < 3; i++)   step(1'($urandom_range(0, 1)), 1'b1);
    for (int i = 0; i < 460; i++) step(1'b1, 1'b0);

`ifdef VGA_TESTPAT_EN
    // Colour bars, then back to pass-through
    phase = 4;
    tp_mode = 1'b1;
    testpat = 1'b1;
    for (int i = 0; i < 2; i++)   step(1'b1, 1'b1);
    for (int i = 0; i < 460; i++) step(1'b1, 1'b0);
    tp_mode = 1'b0;
    testpat = 1'b0;
    for (int i = 0; i < 2; i++)   step(1'b1, 1'b1);
    for (int i = 0; i < 460; i++) step(1'b1, 1'b0);
`endif

    @(negedge clk);
    done = 1'b1;
  end

  // Monitor / scoreboard
  task automatic check_int(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  initial begin
    logic [W-1:0] e, got;
    int cyc = 0, cur_phase = -1;
    int last_ls = -1, last_fs = -1;
    int hs_acc = 0, de_acc = 0, vs_acc = 0;
    int ls_per[5], fs_per[5], hs_line[5], de_frame[5], vs_frame[5];
    int max_ah = 0, max_av = 0;
    for (int i = 0; i < 5; i++) begin
      ls_per[i] = 0; fs_per[i] = 0; hs_line[i] = 0; de_frame[i] = 0; vs_frame[i] = 0;
    end

    while (!done) begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {addrh, addrv, colour_out, hs, vs, de, line_start, frame_start};
        n_checks++;
        if (got !== e) begin
          n_errors++;
          $display("FAIL outputs @%0t: got ah=%0d av=%0d col=%h hs=%b vs=%b de=%b ls=%b fs=%b, expected ah=%0d av=%0d col=%h hs=%b vs=%b de=%b ls=%b fs=%b",
                   $time, got[W-1 -: HCW], got[W-1-HCW -: VCW], got[4+CW -: CW],
                   got[4], got[3], got[2], got[1], got[0],
                   e[W-1 -: HCW], e[W-1-HCW -: VCW], e[4+CW -: CW],
                   e[4], e[3], e[2], e[1], e[0]);
        end

        // Statistics, restarted whenever the stimulus phase changes
        cyc++;
        if (phase != cur_phase) begin
          cur_phase = phase;
          last_ls = -1; last_fs = -1;
          hs_acc = 0; de_acc = 0; vs_acc = 0;
        end
        if (line_start) begin
          if (last_ls >= 0) begin
            ls_per[cur_phase]  = cyc - last_ls;
            hs_line[cur_phase] = hs_acc;
          end
          last_ls = cyc;
          hs_acc  = 0;
        end
        if (frame_start) begin
          if (last_fs >= 0) begin
            fs_per[cur_phase]   = cyc - last_fs;
            de_frame[cur_phase] = de_acc;
            vs_frame[cur_phase] = vs_acc;
          end
          last_fs = cyc;
          de_acc  = 0;
          vs_acc  = 0;
        end
        if (hs == HS_POL) hs_acc++;
        if (vs == VS_POL) vs_acc++;
        if (de) begin
          de_acc++;
          if (int'(addrh) > max_ah) max_ah = int'(addrh);
          if (int'(addrv) > max_av) max_av = int'(addrv);
        end
      end
    end

    // PIX_EN = 1: 56 CLK per line, 448 per frame, HS 8 per line,
    // VS one line (56 CLK) per frame, DE 32 x 4 per frame
    check_int("line_period_en1",  ls_per[1],   56);
    check_int("frame_period_en1", fs_per[1],   448);
    check_int("hs_width_en1",     hs_line[1],  8);
    check_int("vs_width_en1",     vs_frame[1], 56);
    check_int("de_per_frame_en1", de_frame[1], 128);
    // PIX_EN 1-in-4: everything scales by four in CLK
    check_int("line_period_en4",  ls_per[2],   224);
    check_int("frame_period_en4", fs_per[2],   1792);
    check_int("hs_width_en4",     hs_line[2],  32);
    check_int("de_per_frame_en4", de_frame[2], 512);
    // Address range seen while DE is high
    check_int("addrh_max",        max_ah,      31);
    check_int("addrv_max",        max_av,      3);
    check_int("queue_drained",    exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
